// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and defaults for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/operand/result handshake bundle of the serial adder
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - 1-bit full adder cell used for each serial bit step
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, one bit per clock LSB first
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic             fa_s, fa_c;

  full_adder u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // Sum bits enter at the MSB so after WIDTH steps bit 0 sits at the LSB.
  always_comb begin
    s_sh_d            = s_sh_q >> 1;
    s_sh_d[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            state_q <= ADD;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        ADD: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          s_sh_q  <= s_sh_d;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q   <= s_sh_d;
            cout_q  <= fa_c;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder at WIDTH 8 and 2
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Operands are inverted after capture; poke re-asserts start with a different a mid-flight.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [7:0] es, input logic ec, input int poke);
    int n;
    n = 0;
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = ci;
    do begin
      step();
      n++;
      bus8.start = (n == poke);
      if (n == 1) begin
        bus8.a = ~a; bus8.b = ~b; bus8.cin = ~ci;
        check({tag, "_busy"}, 32'(bus8.busy), 32'd1);
      end
      if (n == poke) bus8.a = 8'h77;
    end while (!bus8.done && n < 40);
    check({tag, "_latency"}, 32'(n), 32'd9);
    check({tag, "_sum"}, 32'(bus8.sum), 32'(es));
    check({tag, "_cout"}, 32'(bus8.cout), 32'(ec));
    step();
    check({tag, "_done_pulse"}, 32'(bus8.done), 32'd0);
    check({tag, "_sum_hold"}, 32'(bus8.sum), 32'(es));
  endtask

  initial begin
    int n, m;
    logic [2:0] exp3;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;

    step(); step();
    rst = 1'b0;
    step();
    check("reset_busy", 32'(bus8.busy), 32'd0);
    check("reset_done", 32'(bus8.done), 32'd0);
    check("reset_sum", 32'(bus8.sum), 32'd0);
    check("reset_cout", 32'(bus8.cout), 32'd0);

    run8("basic", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 0);
    step(); step();
    check("basic_hold_sum", 32'(bus8.sum), 32'h08);

    // Asynchronous reset between clock edges
    #3 rst = 1'b1;
    #1;
    check("async_rst_sum", 32'(bus8.sum), 32'd0);
    check("async_rst_busy", 32'(bus8.busy), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_done", 32'(bus8.done), 32'd0);

    run8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    run8("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
    run8("a5_5a_c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0);
    run8("start_ignored", 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 3);

    // Start held high through DONE: second operation follows with no idle cycle
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b0;
    step();
    bus8.a = 8'h03; bus8.b = 8'h04;
    n = 1;
    while (!bus8.done && n < 40) begin step(); n++; end
    check("b2b_first_latency", 32'(n), 32'd9);
    check("b2b_first_sum", 32'(bus8.sum), 32'h03);
    step();
    check("b2b_no_idle", 32'(bus8.busy), 32'd1);
    bus8.start = 1'b0;
    m = 1;
    while (!bus8.done && m < 40) begin step(); m++; end
    check("b2b_spacing", 32'(m), 32'd9);
    check("b2b_second_sum", 32'(bus8.sum), 32'h07);
    step();
    check("b2b_idle_after", 32'(bus8.busy), 32'd0);

    // Reset in ADD cycle 4 aborts with no done pulse
    bus8.start = 1'b1; bus8.a = 8'h40; bus8.b = 8'h40;
    step();
    bus8.start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("mid_rst_sum", 32'(bus8.sum), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus8.done) check("mid_rst_no_done", 32'(bus8.done), 32'd0);
    end
    check("mid_rst_idle", 32'(bus8.busy), 32'd0);
    run8("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0);

    // Reset wins over a simultaneous start
    rst = 1'b1; bus8.start = 1'b1;
    step();
    check("rst_beats_start", 32'(bus8.busy), 32'd0);
    bus8.start = 1'b0; rst = 1'b0;
    step();

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++) begin
          exp3 = 3'(a + b + c);
          bus2.start = 1'b1; bus2.a = 2'(a); bus2.b = 2'(b); bus2.cin = c[0];
          n = 0;
          do begin
            step();
            n++;
            bus2.start = 1'b0; bus2.a = ~2'(a);
          end while (!bus2.done && n < 20);
          check($sformatf("w2_%0d_%0d_%0d_res", a, b, c), 32'({bus2.cout, bus2.sum}), 32'(exp3));
          check($sformatf("w2_%0d_%0d_%0d_lat", a, b, c), 32'(n), 32'd3);
        end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder: adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
- Each cycle's bit addition is done by one instance of the team's 1-bit full adder cell; a carry flip-flop closes the loop between cycles.
- Sits directly downstream of the full-adder cell. It is the area-minimal multi-bit adder used where throughput is not critical.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be at least 1.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      asynchronous, active-high reset
- start  input   1      request to begin an addition; sampled only when busy=0
- a      input   WIDTH  operand A; captured on the accepted start edge
- b      input   WIDTH  operand B; captured on the accepted start edge
- cin    input   1      carry-in; captured on the accepted start edge
- busy   output  1      high while an addition is in progress (ADD state)
- done   output  1      one-cycle pulse: result valid
- sum    output  WIDTH  registered result; held until the next completion
- cout   output  1      registered carry-out; held until the next completion

Behaviour:
- Reset: rst=1 forces the following immediately, regardless of clk:
  - state=IDLE
  - operand shift registers, sum shift register, carry reg and bit counter = 0
  - busy=0, done=0, sum=0, cout=0
- States and transitions:
  - IDLE: start=1 moves to ADD. On that edge, a→A_sh, b→B_sh, cin→carry, counter=0.
  - ADD: on every edge:
    - full-adder inputs are A_sh[0], B_sh[0], carry.
    - The FA sum bit shifts into the MSB of S_sh, which shifts right.
    - carry takes the FA carry-out.
    - A_sh and B_sh shift right, zero fill.
    - counter increments.
  - ADD → DONE: on the edge where counter == WIDTH-1. On that same edge, the final S_sh value (including the bit from that edge) loads into sum, and the final carry loads into cout.
  - DONE: lasts exactly one cycle, with done=1. start=1 here is accepted (back-to-back) and goes to ADD with a fresh capture. Otherwise it returns to IDLE.
- Latency:
  - start accepted at edge k.
  - done=1 in the cycle after edge k+WIDTH.
  - sum and cout are valid from that same cycle.
  - Throughput is one result per WIDTH+1 cycles.
- Output qualifiers:
  - busy=1 only in ADD.
  - done=1 only in DONE.
  - busy and done are never both high.
- start while busy: ignored, with no effect on the operation in flight. Holding start high continuously produces back-to-back operations.
- a, b and cin may change freely after capture; the in-flight result is unaffected.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1). Wrap-around shows only via cout; there is no overflow flag.
- Mid-operation reset: aborts the operation. No done pulse is produced and outputs return to zero. The next start after rst falls behaves normally.
- Simultaneous rst and start: rst wins.
- WIDTH=1: ADD lasts one cycle; done follows on the next cycle.
- Counter width: $clog2(WIDTH) bits, minimum 1.

Decomposition:
- Package serial_adder_pkg holds:
  - the state enum: IDLE, ADD, DONE (2-bit encoding)
  - the default WIDTH constant
- Sub-module: full_adder (the existing 1-bit cell), instantiated exactly once for the per-bit sum.
- All sequencing is in serial_adder itself: FSM, shift registers, carry flop, counter, output registers.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge → busy, done, sum and cout read 0 immediately; after release, idle with no done pulse.
- Basic add (WIDTH=8): a=8'h05, b=8'h03, cin=0, start pulsed at edge k → busy for 8 cycles, done=1 exactly one cycle after edge k+8, sum=8'h08, cout=0. Values hold afterwards until the next completion.
- Carry and wrap:
  - 8'hFF+8'h01, cin=0 → sum=8'h00, cout=1.
  - 8'hFF+8'hFF, cin=1 → sum=8'hFF, cout=1.
  - 8'hA5+8'h5A, cin=1 → sum=8'h00, cout=1.
- Handshake:
  - start pulsed again at ADD cycle 3 with a different a → ignored; the original result is returned.
  - start held high through DONE → the second operation begins with no idle cycle. The second done arrives 9 cycles after the first.
  - Operands changed during ADD → result unaffected.
- Reset mid-operation: rst at ADD cycle 4 → no done, outputs 0. A new start of 8'h10+8'h20 then yields sum=8'h30, cout=0 with normal latency.
- Exhaustive (WIDTH=2): all 32 combinations of a, b and cin → {cout,sum} == a+b+cin for each, done latency 3 cycles each time.
